icache_control_sequencer: RTL and testbench

// - Sequences the 256-entry icache control RAM ({plru[2:0], valid[3:0]}, one entry per 16-byte set, index = address[11:4]).
// - Does read-modify-write per lookup: read entry, classify hit/miss from tag matches, choose victim way, write back pLRU/valid.
// - Arbitrates a code-invalidate request against lookups; sits between icache fetch logic and the control RAM.

---
 rtl/icache_control_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_icache_control_sequencer.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_control_sequencer.sv
// icache control RAM sequencer: read-modify-write of {plru,valid} per lookup,
// victim choice, fill write-back, invalidate arbitration. Optional macro: ICACHE_SEQ_STATS_EN.
//
// Ports: clk/rst_n; lookup_req/lookup_address/lookup_ack; tag_match (EVAL cycle);
// resp_valid/resp_hit/resp_way; fill_done; invd_req/invd_done; busy;
// ram_address/ram_read_do/ram_q/ram_write_do/ram_data/ram_invdcode_do/
// ram_invdcode_done to the control RAM; stat_hits/stat_misses counters.
module icache_control_sequencer #(
  parameter int INIT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lookup_req,
  input  logic [31:0] lookup_address,
  output logic        lookup_ack,
  input  logic [3:0]  tag_match,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [1:0]  resp_way,
  input  logic        fill_done,
  input  logic        invd_req,
  output logic        invd_done,
  output logic        busy,
  output logic [31:0] ram_address,
  output logic        ram_read_do,
  input  logic [6:0]  ram_q,
  output logic        ram_write_do,
  output logic [6:0]  ram_data,
  output logic        ram_invdcode_do,
  input  logic        ram_invdcode_done,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
);

  localparam int CW =
    (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CW-1:0] INIT_LAST =
    CW'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    FILL_WAIT,
    INVD
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  init_cnt_q;
  logic           init_done;
  logic [31:0]    addr_q;
  logic           invd_pend_q;
  logic [1:0]     vic_q;
  logic [2:0]     p_q;
  logic [3:0]     v_q;

  logic           capture;
  logic           miss_cap;
  logic           enter_invd;
  logic [3:0]     v;
  logic [2:0]     p;
  logic [3:0]     m;
  logic [1:0]     hit_way;
  logic [1:0]     victim;

  // Tree pLRU: p[0] picks the pair, p[1]/p[2] the way inside it.
  function automatic logic [1:0] plru_victim(
    input logic [2:0] pl
  );
    if (!pl[0]) return pl[1] ? 2'd1 : 2'd0;
    return pl[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] plru_upd(
    input logic [2:0] pl,
    input logic [1:0] w
  );
    logic [2:0] r;
    r = pl;
    if (!w[1]) begin
      r[0] = 1'b1;
      r[1] = (w == 2'd0);
    end else begin
      r[0] = 1'b0;
      r[2] = (w == 2'd2);
    end
    return r;
  endfunction

  assign v = ram_q[3:0];
  assign p = ram_q[6:4];
  assign m = tag_match & v;

  always_comb begin
    hit_way = 2'd3;
    priority case (1'b1)
      m[0]: hit_way = 2'd0;
      m[1]: hit_way = 2'd1;
      m[2]: hit_way = 2'd2;
      default: hit_way = 2'd3;
    endcase
  end

  // Prefer an invalid way; fall back to pLRU only when the set is full.
  always_comb begin
    victim = plru_victim(p);
    priority case (1'b0)
      v[0]: victim = 2'd0;
      v[1]: victim = 2'd1;
      v[2]: victim = 2'd2;
      v[3]: victim = 2'd3;
      default: victim = plru_victim(p);
    endcase
  end

  assign init_done = (init_cnt_q == INIT_LAST);
  assign busy = (state_q != IDLE) || !init_done;
  assign ram_address =
    ram_read_do ? lookup_address : addr_q;

  always_comb begin
    state_d         = state_q;
    lookup_ack      = 1'b0;
    ram_read_do     = 1'b0;
    ram_write_do    = 1'b0;
    ram_data        = 7'd0;
    ram_invdcode_do = 1'b0;
    invd_done       = 1'b0;
    resp_valid      = 1'b0;
    resp_hit        = 1'b0;
    resp_way        = 2'd0;
    capture         = 1'b0;
    miss_cap        = 1'b0;
    enter_invd      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init_done) begin
          // A same-cycle invd_req also wins over a lookup.
          if (invd_pend_q || invd_req) begin
            ram_invdcode_do = 1'b1;
            enter_invd      = 1'b1;
            state_d         = INVD;
          end else if (lookup_req) begin
            lookup_ack  = 1'b1;
            ram_read_do = 1'b1;
            capture     = 1'b1;
            state_d     = EVAL;
          end
        end
      end
      EVAL: begin
        resp_valid = 1'b1;
        if (|m) begin
          resp_hit     = 1'b1;
          resp_way     = hit_way;
          ram_write_do = 1'b1;
          ram_data     = {plru_upd(p, hit_way), v};
          state_d      = IDLE;
        end else begin
          resp_way = victim;
          miss_cap = 1'b1;
          state_d  = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (fill_done) begin
          ram_write_do = 1'b1;
          ram_data     = {plru_upd(p_q, vic_q),
                          v_q | (4'b0001 << vic_q)};
          state_d      = IDLE;
        end
      end
      INVD: begin
        if (ram_invdcode_done) begin
          invd_done = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      init_cnt_q  <= '0;
      addr_q      <= 32'd0;
      invd_pend_q <= 1'b0;
      vic_q       <= 2'd0;
      p_q         <= 3'd0;
      v_q         <= 4'd0;
    end else begin
      state_q     <= state_d;
      invd_pend_q <= (invd_pend_q | invd_req)
                     & ~enter_invd;
      if (!init_done)
        init_cnt_q <= init_cnt_q + 1'b1;
      if (capture)
        addr_q <= lookup_address;
      if (miss_cap) begin
        vic_q <= victim;
        p_q   <= p;
        v_q   <= v;
      end
    end
  end

`ifdef ICACHE_SEQ_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= 32'd0;
      misses_q <= 32'd0;
    end else if (resp_valid) begin
      if (resp_hit) hits_q <= hits_q + 32'd1;
      else misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = 32'd0;
  assign stat_misses = 32'd0;
`endif

endmodule

// File: tb/tb_icache_control_sequencer.sv
// Scoreboard bench for icache_control_sequencer: a control RAM model,
// expected responses/writes queued at stimulus time and popped on output.
module tb_icache_control_sequencer;

  localparam int INIT = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_req = 1'b0;
  logic [31:0] lookup_address = 32'd0;
  logic        lookup_ack;
  logic [3:0]  tag_match = 4'd0;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        fill_done = 1'b0;
  logic        invd_req = 1'b0;
  logic        invd_done;
  logic        busy;
  logic [31:0] ram_address;
  logic        ram_read_do;
  logic [6:0]  ram_q = 7'd0;
  logic        ram_write_do;
  logic [6:0]  ram_data;
  logic        ram_invdcode_do;
  logic        ram_invdcode_done = 1'b0;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;

  icache_control_sequencer #(.INIT_CYCLES(INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_req(lookup_req),
    .lookup_address(lookup_address),
    .lookup_ack(lookup_ack),
    .tag_match(tag_match),
    .resp_valid(resp_valid),
    .resp_hit(resp_hit),
    .resp_way(resp_way),
    .fill_done(fill_done),
    .invd_req(invd_req),
    .invd_done(invd_done),
    .busy(busy),
    .ram_address(ram_address),
    .ram_read_do(ram_read_do),
    .ram_q(ram_q),
    .ram_write_do(ram_write_do),
    .ram_data(ram_data),
    .ram_invdcode_do(ram_invdcode_do),
    .ram_invdcode_done(ram_invdcode_done),
    .stat_hits(stat_hits),
    .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic [1:0] way;
    logic [6:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t fq[$];
  logic [6:0] mem [256];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e_hits = 0;
  int e_misses = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(posedge clk)
    if (ram_read_do) ram_q <= mem[ram_address[11:4]];

  function automatic logic [1:0] m_victim(input logic [2:0] pl);
    casez (pl)
      3'b?00: return 2'd0;
      3'b?10: return 2'd1;
      3'b0?1: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [2:0] m_upd(
    input logic [2:0] pl, input logic [1:0] w
  );
    case (w)
      2'd0: return {pl[2], 1'b1, 1'b1};
      2'd1: return {pl[2], 1'b0, 1'b1};
      2'd2: return {1'b1, pl[1], 1'b0};
      default: return {1'b0, pl[1], 1'b0};
    endcase
  endfunction

  function automatic exp_t model(
    input logic [6:0] e, input logic [3:0] match
  );
    exp_t r;
    logic [3:0] vv, mm;
    vv = e[3:0];
    mm = match & vv;
    if (mm != 4'd0) begin
      r.hit = 1'b1;
      r.way = mm[0] ? 2'd0 : mm[1] ? 2'd1 : mm[2] ? 2'd2 : 2'd3;
      r.data = {m_upd(e[6:4], r.way), vv};
    end else begin
      r.hit = 1'b0;
      if (vv != 4'hF)
        r.way = !vv[0] ? 2'd0 : !vv[1] ? 2'd1 : !vv[2] ? 2'd2 : 2'd3;
      else
        r.way = m_victim(e[6:4]);
      r.data = {m_upd(e[6:4], r.way), vv | (4'b0001 << r.way)};
    end
    return r;
  endfunction

  task automatic lk_ack(input logic [31:0] a, output int at,
                        output bit idle_seen);
    at = -1;
    idle_seen = 0;
    lookup_req = 1'b1;
    lookup_address = a;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (lookup_ack) begin
        at = cyc;
        break;
      end
      if (!busy) idle_seen = 1;
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL ack_timeout addr=%h", a);
    end else begin
      checks++;
      if (ram_read_do !== 1'b1 || ram_address !== a) begin
        errors++;
        $display("FAIL ack_read rd=%b adr=%h want rd=1 adr=%h",
                 ram_read_do, ram_address, a);
      end
    end
    @(posedge clk) #1;
    lookup_req = 1'b0;
  endtask

  task automatic lk_eval(input logic [31:0] a, input logic [3:0] match);
    exp_t x, g;
    x = model(mem[a[11:4]], match);
    sbq.push_back(x);
    tag_match = match;
    @(negedge clk);
    g = sbq.pop_front();
    checks++;
    if (resp_valid !== 1'b1 || resp_hit !== g.hit || resp_way !== g.way) begin
      errors++;
      $display("FAIL resp addr=%h got v=%b h=%b w=%0d want v=1 h=%b w=%0d",
               a, resp_valid, resp_hit, resp_way, g.hit, g.way);
    end
    checks++;
    if (g.hit) begin
      e_hits++;
      if (ram_write_do !== 1'b1 || ram_data !== g.data || ram_address !== a) begin
        errors++;
        $display("FAIL hit_write we=%b d=%b adr=%h want d=%b adr=%h",
                 ram_write_do, ram_data, ram_address, g.data, a);
      end
    end else begin
      e_misses++;
      fq.push_back(g);
      if (ram_write_do !== 1'b0) begin
        errors++;
        $display("FAIL miss_nowrite we=%b want 0", ram_write_do);
      end
    end
    @(posedge clk) #1;
    tag_match = 4'd0;
  endtask

  task automatic lk_fill(input logic [31:0] a);
    exp_t f;
    fill_done = 1'b1;
    @(negedge clk);
    checks++;
    if (fq.size() == 0) begin
      errors++;
      $display("FAIL fill_noexp addr=%h", a);
    end else begin
      f = fq.pop_front();
      if (ram_write_do !== 1'b1 || ram_data !== f.data || ram_address !== a) begin
        errors++;
        $display("FAIL fill_write we=%b d=%b adr=%h want d=%b adr=%h",
                 ram_write_do, ram_data, ram_address, f.data, a);
      end
    end
    @(posedge clk) #1;
    fill_done = 1'b0;
  endtask

  task automatic test_reset;
    int at;
    bit idl;
    repeat (3) @(negedge clk);
    checks++;
    if ({lookup_ack, resp_valid, resp_hit, resp_way, invd_done, ram_address,
         ram_read_do, ram_write_do, ram_data, ram_invdcode_do,
         stat_hits, stat_misses} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b rv=%b adr=%h we=%b want all 0",
               lookup_ack, resp_valid, ram_address, ram_write_do);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy got %b want 1", busy);
    end
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    mem[8'h12] = 7'd0;
    lk_ack(32'h0000_0120, at, idl);
    checks++;
    if (at != INIT - 1 || idl) begin
      errors++;
      $display("FAIL init_wait ack_cyc=%0d idle_seen=%0d want %0d 0",
               at, idl, INIT - 1);
    end
    lk_eval(32'h0000_0120, 4'b0000);
    lk_fill(32'h0000_0120);
  endtask

  task automatic test_hit;
    int at;
    bit idl;
    mem[8'h34] = 7'b000_1111;
    lk_ack(32'hABCD_E340, at, idl);
    lk_eval(32'hABCD_E340, 4'b0100);
  endtask

  task automatic test_victim_plru;
    int at;
    bit idl;
    bit bad;
    mem[8'h56] = 7'b001_1111;
    lk_ack(32'h0000_0560, at, idl);
    lk_eval(32'h0000_0560, 4'b0000);
    lookup_req = 1'b1;
    lookup_address = 32'h0000_0770;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (lookup_ack || ram_read_do || ram_write_do || !busy) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fill_wait_quiet got access/idle want none");
    end
    lookup_req = 1'b0;
    @(posedge clk) #1;
    lk_fill(32'h0000_0560);
  endtask

  task automatic test_masked_match;
    int at;
    bit idl;
    mem[8'h78] = 7'b010_0101;
    lk_ack(32'h0000_0780, at, idl);
    lk_eval(32'h0000_0780, 4'b1010);
    lk_fill(32'h0000_0780);
  endtask

  task automatic test_back_to_back;
    logic [31:0] ad [4];
    logic [6:0]  q  [4];
    logic [3:0]  tm [4];
    int at, prev;
    bit idl;
    ad = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0FF0};
    q  = '{7'b110_1111, 7'b011_1111, 7'b101_1111, 7'b000_1111};
    tm = '{4'b0110, 4'b0000, 4'b1000, 4'b0000};
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      mem[ad[i][11:4]] = q[i];
      lk_ack(ad[i], at, idl);
      if (prev >= 0) begin
        checks++;
        if (at != prev + 2) begin
          errors++;
          $display("FAIL b2b_ack cyc=%0d want %0d", at, prev + 2);
        end
      end
      lk_eval(ad[i], tm[i]);
      if (tm[i] == 4'd0) begin
        lk_fill(ad[i]);
        prev = -1;
      end else begin
        prev = at;
      end
    end
  endtask

  task automatic test_invd_during_fill;
    int at;
    bit idl;
    mem[8'h9A] = 7'd0;
    lk_ack(32'h0000_09A0, at, idl);
    lk_eval(32'h0000_09A0, 4'b0000);
    invd_req = 1'b1;
    @(posedge clk) #1;
    invd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_invdcode_do !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL invd_held do=%b busy=%b want 0 1", ram_invdcode_do, busy);
    end
    @(posedge clk) #1;
    lk_fill(32'h0000_09A0);
    @(negedge clk);
    checks++;
    if (ram_invdcode_do !== 1'b1 || invd_done !== 1'b0) begin
      errors++;
      $display("FAIL invd_start do=%b done=%b want 1 0", ram_invdcode_do, invd_done);
    end
    @(posedge clk) #1;
    @(negedge clk);
    checks++;
    if (ram_invdcode_do !== 1'b0 || busy !== 1'b1 || invd_done !== 1'b0) begin
      errors++;
      $display("FAIL invd_wait do=%b busy=%b done=%b want 0 1 0",
               ram_invdcode_do, busy, invd_done);
    end
    @(posedge clk) #1;
    ram_invdcode_done = 1'b1;
    @(negedge clk);
    checks++;
    if (invd_done !== 1'b1) begin
      errors++;
      $display("FAIL invd_done got %b want 1", invd_done);
    end
    @(posedge clk) #1;
    ram_invdcode_done = 1'b0;
    @(negedge clk);
    checks++;
    if (invd_done !== 1'b0 || busy !== 1'b0 || ram_invdcode_do !== 1'b0) begin
      errors++;
      $display("FAIL invd_end done=%b busy=%b do=%b want 0 0 0",
               invd_done, busy, ram_invdcode_do);
    end
    @(posedge clk) #1;
  endtask

  task automatic test_invd_vs_lookup;
    int at, dc;
    bit idl, bad;
    mem[8'hBC] = 7'b000_1111;
    invd_req = 1'b1;
    lookup_req = 1'b1;
    lookup_address = 32'h0000_0BC0;
    @(negedge clk);
    checks++;
    if (ram_invdcode_do !== 1'b1 || lookup_ack !== 1'b0) begin
      errors++;
      $display("FAIL arb_first do=%b ack=%b want 1 0", ram_invdcode_do, lookup_ack);
    end
    @(posedge clk) #1;
    invd_req = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (lookup_ack) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL arb_no_ack got ack during INVD want none");
    end
    @(posedge clk) #1;
    ram_invdcode_done = 1'b1;
    @(negedge clk);
    dc = cyc;
    checks++;
    if (invd_done !== 1'b1 || lookup_ack !== 1'b0) begin
      errors++;
      $display("FAIL arb_done done=%b ack=%b want 1 0", invd_done, lookup_ack);
    end
    @(posedge clk) #1;
    ram_invdcode_done = 1'b0;
    lk_ack(32'h0000_0BC0, at, idl);
    checks++;
    if (at != dc + 1) begin
      errors++;
      $display("FAIL arb_ack_cyc got %0d want %0d", at, dc + 1);
    end
    lk_eval(32'h0000_0BC0, 4'b0001);
  endtask

  task automatic test_stats;
    int at, h0, m0;
    bit idl;
    h0 = e_hits;
    m0 = e_misses;
    for (int i = 0; i < 5; i++) begin
      mem[8'hC0 + i] = (i < 3) ? 7'b000_1111 : 7'b000_0000;
      lk_ack(32'h0000_0C00 + 32'(i * 16), at, idl);
      lk_eval(32'h0000_0C00 + 32'(i * 16), (i < 3) ? 4'b0010 : 4'b0000);
      if (i >= 3) lk_fill(32'h0000_0C00 + 32'(i * 16));
    end
    @(negedge clk);
    checks++;
`ifdef ICACHE_SEQ_STATS_EN
    if (e_hits - h0 != 3 || e_misses - m0 != 2 ||
        stat_hits !== 32'(e_hits) || stat_misses !== 32'(e_misses)) begin
      errors++;
      $display("FAIL stats got %0d/%0d want %0d/%0d",
               stat_hits, stat_misses, e_hits, e_misses);
    end
`else
    if (e_hits - h0 != 3 || e_misses - m0 != 2 ||
        stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      errors++;
      $display("FAIL stats_off got %0d/%0d want 0/0", stat_hits, stat_misses);
    end
`endif
    @(posedge clk) #1;
  endtask

  task automatic test_reset_midop;
    int at;
    bit idl;
    mem[8'hDE] = 7'b000_1111;
    lk_ack(32'h0000_0DE0, at, idl);
    tag_match = 4'b0001;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || ram_write_do !== 1'b0 || busy !== 1'b1 ||
        stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      errors++;
      $display("FAIL midop_reset rv=%b we=%b busy=%b st=%0d/%0d want 0 0 1 0/0",
               resp_valid, ram_write_do, busy, stat_hits, stat_misses);
    end
    tag_match = 4'd0;
    e_hits = 0;
    e_misses = 0;
    #1 rst_n = 1'b1;
    lk_ack(32'h0000_0DE0, at, idl);
    checks++;
    if (at != INIT - 1) begin
      errors++;
      $display("FAIL midop_init ack_cyc=%0d want %0d", at, INIT - 1);
    end
    lk_eval(32'h0000_0DE0, 4'b0001);
    @(negedge clk);
    checks++;
`ifdef ICACHE_SEQ_STATS_EN
    if (stat_hits !== 32'd1 || stat_misses !== 32'd0) begin
      errors++;
      $display("FAIL midop_stats got %0d/%0d want 1/0", stat_hits, stat_misses);
    end
`else
    if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      errors++;
      $display("FAIL midop_stats got %0d/%0d want 0/0", stat_hits, stat_misses);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 7'd0;
    test_reset();
    test_hit();
    test_victim_plru();
    test_masked_match();
    test_back_to_back();
    test_invd_during_fill();
    test_invd_vs_lookup();
    test_stats();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
